prim_fifo_unpack: RTL and testbench
===================================

# prim_fifo_unpack

Single-clock width down-converter that sits directly on the read port of the asynchronous FIFO primitive. It accepts wide words through a valid/ready handshake (rvalid/rready/rdata on the FIFO side) and emits them as a sequence of narrower beats with a last-beat flag. Throughput is one beat per cycle, with no bubble between consecutive words. It lives in the read clock domain; no clock-domain crossing happens inside it.

## Interface
- InW, default 32: input word width; must be an integer multiple of OutW.
- OutW, default 8: output beat width.
- Ratio (localparam) = InW/OutW: beats per word; must be ≥ 2.
- CntW (localparam) = $clog2(Ratio): beat index width.

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  word available; connects to FIFO rvalid_o.
- in_ready_o  out  1  word accepted this cycle when high with in_valid_i; connects to FIFO rready_i.
- in_data_i  in  InW  word; connects to FIFO rdata_o.
- out_valid_o  out  1  beat valid.
- out_ready_i  in  1  downstream accepts the beat.
- out_data_o  out  OutW  current beat.
- out_last_o  out  1  current beat is the final beat of its word.
- flush_i  in  1  synchronous drop of the held word.
- idle_o  out  1  no word held.

## Operation
- State machine: IDLE (no word held) and BUSY (word in data_q, beat index cnt_q).
- IDLE: in_ready_o=1. On in_valid_i, latch in_data_i into data_q, set cnt_q=0, go to BUSY.
- BUSY: out_valid_o=1. out_data_o = data_q[cnt_q*OutW +: OutW], using the default beat order.
- BUSY beat transfer (out_valid_o & out_ready_i), when cnt_q≠Ratio-1: cnt_q increments.
- BUSY last beat (cnt_q==Ratio-1), out_last_o=1:
  - On transfer with in_valid_i: load the new word, cnt_q=0, stay BUSY. This is the no-bubble path.
  - On transfer without in_valid_i: go to IDLE.
- in_ready_o = !flush_i & (IDLE | (out_ready_i & out_last_o)). This is a combinational path from out_ready_i to in_ready_o, which is acceptable because the FIFO's rready_i has no path back to our inputs.
- out_valid_o is never withdrawn and out_data_o never changes while out_valid_o & !out_ready_i.
- flush_i (any state): next state IDLE and cnt_q=0. No input is accepted in that cycle. An output transfer in the same cycle still counts as delivered.
- Arithmetic: cnt_q is CntW bits and never wraps past Ratio-1. data_q is not cleared on return to IDLE.
- Reset values: state IDLE, cnt_q 0, data_q 0. Outputs after reset: in_ready_o=1, out_valid_o=0, out_data_o=0, out_last_o=0, idle_o=1.
- Reset mid-word: the held word is discarded and none of its remaining beats are emitted.

## Timing
- Word accepted at rising edge N; its first beat is valid in the cycle after N.
- Word latency to last beat: Ratio cycles with out_ready_i held high.
- Sustained rate: one word per Ratio cycles, one beat per cycle.
- With out_ready_i stalled, the beat holds indefinitely and in_ready_o stays low.
- Outputs are derived from registers only, except in_ready_o, which is combinational.

## Configuration
- PRIM_FIFO_UNPACK_MSB_FIRST_EN defined: beat k = data_q[InW-1-k*OutW -: OutW], i.e. most-significant beat first.
- Undefined (default): least-significant beat first, as specified in Operation.
- The macro affects only the slice selection; handshake and timing are identical in both cases.

## Structure
- prim_fifo_unpack_pkg holds:
  - the state typedef (enum logic {StIdle, StBusy});
  - a function computing the beat slice offset for a given cnt_q.
- Parameter checks (InW%OutW==0, Ratio≥2) are init-time assertions in the module.
- No sub-module is needed. The beat counter and data register are a single always_ff each.

## Test plan
- Reset: assert rst_ni low mid-word → in_ready_o=1, out_valid_o=0, idle_o=1; no beat of the interrupted word appears after release.
- Single word, InW=32, OutW=8: word 0xAABBCCDD with out_ready_i=1 → beats DD, CC, BB, AA on four consecutive cycles, out_last_o only on AA. With the macro defined: AA, BB, CC, DD.
- Back-to-back: words 0x03020100 then 0x07060504 with continuous valid and ready → eight beats 00…07 in eight consecutive cycles, no gap, in_ready_o high on the cycles of beats 03 and 07.
- Backpressure: hold out_ready_i=0 for 5 cycles on beat 2 of 0x44332211 → out_data_o stays 0x33, in_ready_o stays 0, and the beat sequence resumes unaltered.
- Flush on beat 1 of 0x11111111 with in_valid_i=1 → the next cycle is IDLE, the pending word is not accepted that cycle and is accepted the cycle after.
- Driven from the async FIFO (Depth 4): write 4 words, drain → exactly 16 beats in order; FIFO rdepth_o returns to 0.

Source files
------------

// File: rtl/prim_fifo_unpack_pkg.sv
// prim_fifo_unpack_pkg
//   Shared types and helpers for the prim_fifo_unpack width down-converter.
//   - state_e     : unpacker state encoding.
//   - beat_offset : bit offset of beat `cnt` inside a held word.
//   Beat order is set by PRIM_FIFO_UNPACK_MSB_FIRST_EN. Defined: the most
//   significant beat goes first. Undefined (the default): the least
//   significant beat goes first.
package prim_fifo_unpack_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic int beat_offset(input int cnt, input int in_w, input int out_w);
`ifdef PRIM_FIFO_UNPACK_MSB_FIRST_EN
        // Returns the low bit of the slice, so the caller can use +: in both orders.
        return in_w - (cnt + 1) * out_w;
`else
        return cnt * out_w;
`endif
    endfunction

endpackage

// File: rtl/prim_fifo_unpack.sv
// prim_fifo_unpack
//   Single-clock width down-converter for the read port of the async FIFO.
//   It accepts one InW-bit word and emits it as InW/OutW beats of OutW bits.
//   When the last beat of a word is taken in the same cycle that a new word
//   arrives, the new word loads at once, so consecutive words have no gap.
//   PRIM_FIFO_UNPACK_MSB_FIRST_EN (optional define) sends the most
//   significant beat first. Without it, the least significant beat goes first.
//
// Ports
//   clk_i        sole clock
//   rst_ni       async active-low reset
//   in_valid_i   word available        (FIFO rvalid_o)
//   in_ready_o   word accepted         (FIFO rready_i); combinational
//   in_data_i    InW-bit word          (FIFO rdata_o)
//   out_valid_o  beat valid
//   out_ready_i  downstream takes the beat
//   out_data_o   current OutW-bit beat
//   out_last_o   current beat is the final beat of its word
//   flush_i      synchronous drop of the held word
//   idle_o       no word held
//
// state  | meaning
// -------+-----------------------------------------------------
// StIdle | no word held; ready for a new word
// StBusy | word held in data_q; cnt_q selects the current beat
module prim_fifo_unpack
    import prim_fifo_unpack_pkg::*;
#(
    parameter int InW  = 32,
    parameter int OutW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [InW-1:0]  in_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [OutW-1:0] out_data_o,
    output logic            out_last_o,
    input  logic            flush_i,
    output logic            idle_o
);

    localparam int Ratio = InW / OutW;
    localparam int CntW  = $clog2(Ratio);
    localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

    if ((InW % OutW) != 0) begin : g_chk_multiple
        $error("prim_fifo_unpack: InW must be an integer multiple of OutW");
    end
    if (Ratio < 2) begin : g_chk_ratio
        $error("prim_fifo_unpack: InW/OutW must be at least 2");
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [InW-1:0]  data_q;
    logic            busy;
    logic            load;

    assign busy        = (state_q == StBusy);
    assign out_valid_o = busy;
    assign out_last_o  = busy & (cnt_q == LastCnt);
    assign idle_o      = ~busy;

    // A new word is taken only when no beat is pending after this edge.
    // That happens when idle, or when the last beat leaves in this cycle.
    assign in_ready_o  = ~flush_i & (~busy | (out_ready_i & out_last_o));
    assign load        = in_valid_i & in_ready_o;

    assign out_data_o  = data_q[beat_offset(int'(cnt_q), InW, OutW) +: OutW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        state_d = StBusy;
                        cnt_d   = '0;
                    end
                end
                StBusy: begin
                    if (out_ready_i) begin
                        if (cnt_q != LastCnt) begin
                            cnt_d = cnt_q + CntW'(1);
                        end else begin
                            cnt_d = '0;
                            if (!in_valid_i) begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // data_q keeps its value on return to idle. Only a reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= in_data_i;
        end
    end

endmodule

// File: tb/tb_prim_fifo_unpack.sv
module tb_prim_fifo_unpack;

    localparam int InW   = 32;
    localparam int OutW  = 8;
    localparam int Ratio = InW / OutW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [InW-1:0]  in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OutW-1:0] out_data;
    logic            out_last;
    logic            flush = 1'b0;
    logic            idle;

    int total = 0;
    int bad   = 0;
    int n_beats = 0;

    prim_fifo_unpack #(.InW(InW), .OutW(OutW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .flush_i     (flush),
        .idle_o      (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of beats that are still to come out.
    typedef struct packed {
        logic [OutW-1:0] d;
        logic            l;
    } beat_t;
    beat_t mq[$];

    function automatic logic [OutW-1:0] model_beat(input logic [InW-1:0] w, input int k);
        logic [InW-1:0] t;
`ifdef PRIM_FIFO_UNPACK_MSB_FIRST_EN
        t = w >> (InW - (k + 1) * OutW);
`else
        t = w >> (k * OutW);
`endif
        return t[OutW-1:0];
    endfunction

    logic exp_v, exp_rdy;
    beat_t nb;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_idle", idle, 1);
            chk("rst_out_data", out_data, 0);
        end else begin
            exp_v   = (mq.size() > 0);
            exp_rdy = !flush && (!exp_v || (out_ready && mq[0].l));
            chk("m_out_valid", out_valid, exp_v);
            chk("m_idle", idle, !exp_v);
            chk("m_in_ready", in_ready, exp_rdy);
            if (exp_v) begin
                chk("m_out_data", out_data, mq[0].d);
                chk("m_out_last", out_last, mq[0].l);
            end else begin
                chk("m_out_last_idle", out_last, 0);
            end
            if (exp_v && out_ready) begin
                void'(mq.pop_front());
                n_beats++;
            end
            if (flush) begin
                mq.delete();
            end else if (in_valid && exp_rdy) begin
                for (int k = 0; k < Ratio; k++) begin
                    nb.d = model_beat(in_data, k);
                    nb.l = (k == Ratio - 1);
                    mq.push_back(nb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [7:0] t1_exp [4];
    logic [7:0] b2b_exp [8];
    logic [7:0] bp_exp [4];
    logic [7:0] fl_first;
    logic [InW-1:0] fq[$];
    int base;

    initial begin
`ifdef PRIM_FIFO_UNPACK_MSB_FIRST_EN
        t1_exp  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        b2b_exp = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h07, 8'h06, 8'h05, 8'h04};
        bp_exp  = '{8'h44, 8'h33, 8'h22, 8'h11};
        fl_first = 8'h99;
`else
        t1_exp  = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        b2b_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        bp_exp  = '{8'h11, 8'h22, 8'h33, 8'h44};
        fl_first = 8'h66;
`endif
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Single word
        in_valid = 1'b1; in_data = 32'hAABBCCDD; out_ready = 1'b1;
        mid(); chk("t1_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("t1_data", out_data, t1_exp[k]);
            chk("t1_last", out_last, (k == 3));
            tick();
        end
        mid(); chk("t1_idle", idle, 1); chk("t1_valid_off", out_valid, 0);
        tick();

        // Back-to-back words, no bubble
        in_valid = 1'b1; in_data = 32'h03020100;
        mid(); tick();
        in_data = 32'h07060504;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", out_data, b2b_exp[i]);
            chk("b2b_in_ready", in_ready, (i == 3 || i == 7));
            tick();
            if (i == 3) in_valid = 1'b0;
        end

        // Backpressure on beat 2
        in_valid = 1'b1; in_data = 32'h44332211;
        mid(); tick(); in_valid = 1'b0;
        mid(); chk("bp_b0", out_data, bp_exp[0]); tick();
        mid(); chk("bp_b1", out_data, bp_exp[1]); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("bp_hold_data", out_data, bp_exp[2]);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        mid(); chk("bp_b2", out_data, bp_exp[2]); tick();
        mid(); chk("bp_b3", out_data, bp_exp[3]); chk("bp_b3_last", out_last, 1); tick();

        // Flush on beat 1
        in_valid = 1'b1; in_data = 32'h11111111;
        mid(); tick(); in_valid = 1'b0;
        mid(); chk("fl_b0", out_data, 8'h11); tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h99887766;
        mid(); chk("fl_in_ready", in_ready, 0); chk("fl_valid", out_valid, 1);
        tick(); flush = 1'b0;
        mid(); chk("fl_idle", idle, 1); chk("fl_accept", in_ready, 1);
        tick(); in_valid = 1'b0;
        mid(); chk("fl_new_valid", out_valid, 1); chk("fl_new_data", out_data, fl_first);
        tick();
        repeat (3) tick();

        // Reset mid-word
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        mid(); tick(); in_valid = 1'b0;
        mid(); tick();
        rst_n = 1'b0;
        mid();
        chk("rm_in_ready", in_ready, 1);
        chk("rm_valid", out_valid, 0);
        chk("rm_idle", idle, 1);
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("rm_no_beat", out_valid, 0); tick();
        end

        // Drain four words from a FIFO-like source, with some stalls on the output
        fq = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        base = n_beats;
        for (int c = 0; c < 40; c++) begin
            in_valid  = (fq.size() > 0);
            in_data   = (fq.size() > 0) ? fq[0] : '0;
            out_ready = ((c % 5) != 3);
            mid();
            if (in_valid && in_ready) void'(fq.pop_front());
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        mid();
        chk("fifo_beats", n_beats - base, 16);
        chk("fifo_depth", fq.size(), 0);
        chk("fifo_idle", idle, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
